// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-cold column strobes, whole-frame single-key debounce,
// and a small key-code FIFO with valid/ready pop and a sticky overflow flag.
//
// state | meaning
// IDLE  | nothing accepted; waiting for a clean single-key frame
// CAND  | the same key has been seen in cnt consecutive frames
// HELD  | key queued; waiting for DEBOUNCE consecutive empty frames
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 4,
    parameter int DEBOUNCE   = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(ROWS*COLS),
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            en,
    input  logic            clr,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic            key_valid,
    output logic [CW-1:0]   key_code,
    input  logic            key_ready,
    output logic            overflow,
    output logic [AW:0]     fifo_count
);

    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam int DVW = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE+1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAND = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    localparam logic [DBW-1:0] DB_TC  = DBW'(DEBOUNCE);
    localparam logic [DVW-1:0] DW_END = DVW'(SCAN_DIV-1);
    localparam logic [CLW-1:0] C_END  = CLW'(COLS-1);

    logic [ROWS-1:0] row_s1, row_s2;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            row_s1 <= '0;
            row_s2 <= '0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    logic [CLW-1:0] col_idx;
    logic [DVW-1:0] dwell;
    logic           sample;
    logic           last_col;

    assign sample   = en && (dwell == DW_END);
    assign last_col = (col_idx == C_END);

    // col_out lags col_idx by one cycle, so each column is driven for SCAN_DIV
    // cycles and the sample lands SCAN_DIV-1 cycles after the strobe changed.
    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            col_idx <= '0;
            dwell   <= '0;
            col_out <= '1;
        end else begin
            col_out <= ~(COLS'(1) << col_idx);
            if (dwell == DW_END) begin
                dwell   <= '0;
                col_idx <= last_col ? '0 : col_idx + CLW'(1);
            end else begin
                dwell <= dwell + DVW'(1);
            end
        end
    end

    logic          s_any, s_many;
    logic [RW-1:0] s_row;
    logic [CW-1:0] s_code;

    always_comb begin
        s_any  = 1'b0;
        s_many = 1'b0;
        s_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_s2[r]) begin
                if (s_any) s_many = 1'b1;
                s_any = 1'b1;
                s_row = RW'(r);
            end
        end
    end

    assign s_code = CW'(int'(col_idx) * ROWS + int'(s_row));

    logic          acc_hit, acc_bad;
    logic [CW-1:0] acc_code;
    logic          m_hit, m_bad;
    logic [CW-1:0] m_code;
    logic          fr_valid, fr_key, fr_none;

    // A second single-hit column makes the frame MULTI just like a multi-row column.
    assign m_hit  = acc_hit | (s_any & ~s_many);
    assign m_bad  = acc_bad | s_many | (s_any & ~s_many & acc_hit);
    assign m_code = acc_hit ? acc_code : s_code;

    assign fr_valid = sample & last_col;
    assign fr_key   = fr_valid & m_hit & ~m_bad;
    assign fr_none  = fr_valid & ~m_hit & ~m_bad;

    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            acc_hit  <= 1'b0;
            acc_bad  <= 1'b0;
            acc_code <= '0;
        end else if (sample) begin
            if (last_col) begin
                acc_hit  <= 1'b0;
                acc_bad  <= 1'b0;
                acc_code <= '0;
            end else begin
                acc_hit  <= m_hit;
                acc_bad  <= m_bad;
                acc_code <= m_code;
            end
        end
    end

    logic [1:0]     state;
    logic [CW-1:0]  cand;
    logic [DBW-1:0] cnt;
    logic           cnt_tc;
    logic           push;

    assign cnt_tc = ((cnt + DBW'(1)) == DB_TC);

    always_comb begin
        push = 1'b0;
        if (fr_key && state == ST_IDLE && DEBOUNCE == 1) push = 1'b1;
        if (fr_key && state == ST_CAND && m_code == cand && cnt_tc) push = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nrst || !en) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else if (fr_valid) begin
            case (state)
                ST_IDLE: begin
                    if (fr_key) begin
                        cand <= m_code;
                        if (DEBOUNCE == 1) begin
                            state <= ST_HELD;
                            cnt   <= '0;
                        end else begin
                            state <= ST_CAND;
                            cnt   <= DBW'(1);
                        end
                    end
                end
                ST_CAND: begin
                    if (!fr_key) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (m_code != cand) begin
                        cand <= m_code;
                        cnt  <= DBW'(1);
                    end else if (cnt_tc) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DBW'(1);
                    end
                end
                ST_HELD: begin
                    // Any activity while held restarts the release count; no rollover.
                    if (!fr_none) begin
                        cnt <= '0;
                    end else if (cnt_tc) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DBW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    logic [CW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, pop, wr_en;

    assign empty     = (fifo_count == '0);
    assign full      = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign key_valid = ~empty;
    assign pop       = key_valid & key_ready;
    assign wr_en     = push & (~full | pop);
    assign key_code  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!nrst || clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && nrst && !clr) mem[wr_ptr] <= m_code;
    end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo at default parameters; row_in is derived
// from col_out and a per-column pressed-rows pattern (nibble c = rows on column c).
module tb_keypad_scan_fifo;

    logic       clk = 1'b0;
    logic       nrst, en, clr, key_ready;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, overflow;
    logic [2:0] fifo_count;
    logic [15:0] pat;

    int checks = 0;
    int errors = 0;

    keypad_scan_fifo dut (
        .clk(clk), .nrst(nrst), .en(en), .clr(clr), .row_in(row_in),
        .col_out(col_out), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = '0;
        for (int c = 0; c < 4; c++)
            if (!col_out[c]) row_in = row_in | pat[4*c +: 4];
    end

    typedef struct {
        logic       en;
        logic [3:0] col;
    } scan_vec_t;

    typedef struct {
        logic [15:0] pat_a;
        int          na;
        logic [15:0] pat_b;
        int          nb;
        int          nr;
        int          count;
        logic        ovf;
    } press_vec_t;

    scan_vec_t  scan_tab[22];
    press_vec_t press_tab[8];
    logic [3:0] col_seq[4];
    logic [3:0] pop_exp[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [15:0] a, input int na, input logic [15:0] b,
                         input int nb, input int nr);
        pat = a;
        tick(16*na);
        pat = b;
        tick(16*nb);
        pat = '0;
        tick(16*nr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; en = 1'b1; clr = 1'b0; key_ready = 1'b0; pat = '0;

        col_seq[0] = 4'he; col_seq[1] = 4'hd; col_seq[2] = 4'hb; col_seq[3] = 4'h7;
        for (int i = 0; i < 16; i++) scan_tab[i] = '{1'b1, col_seq[i/4]};
        scan_tab[16] = '{1'b0, 4'hf};
        for (int i = 17; i < 21; i++) scan_tab[i] = '{1'b1, 4'he};
        scan_tab[21] = '{1'b1, 4'hd};

        press_tab[0] = '{16'h0800, 2, 16'h0000, 0, 2, 2, 1'b0};
        press_tab[1] = '{16'h0003, 3, 16'h0000, 0, 2, 2, 1'b0};
        press_tab[2] = '{16'h0022, 3, 16'h0000, 0, 2, 2, 1'b0};
        press_tab[3] = '{16'h0001, 1, 16'h0000, 0, 1, 2, 1'b0};
        press_tab[4] = '{16'h0001, 1, 16'h0000, 0, 1, 2, 1'b0};
        press_tab[5] = '{16'h0001, 1, 16'h0020, 2, 2, 3, 1'b0};
        press_tab[6] = '{16'h0040, 2, 16'h2000, 2, 2, 4, 1'b0};
        press_tab[7] = '{16'h0008, 2, 16'h0000, 0, 2, 4, 1'b1};

        pop_exp[0] = 4'd0; pop_exp[1] = 4'd11; pop_exp[2] = 4'd5; pop_exp[3] = 4'd6;

        tick(3);
        check("rst_col_out", col_out, 4'hf);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);

        nrst = 1'b1;
        for (int i = 0; i < 22; i++) begin
            en = scan_tab[i].en;
            tick(1);
            check($sformatf("scan[%0d]", i), col_out, scan_tab[i].col);
        end
        tick(11);

        pat = 16'h0001;
        tick(31);
        check("latency_early", key_valid, 1'b0);
        tick(1);
        check("latency_valid", key_valid, 1'b1);
        check("latency_code", key_code, 4'd0);
        tick(16);
        pat = '0;
        tick(32);
        check("release_count", fifo_count, 3'd1);

        for (int i = 0; i < 8; i++) begin
            press(press_tab[i].pat_a, press_tab[i].na, press_tab[i].pat_b,
                  press_tab[i].nb, press_tab[i].nr);
            check($sformatf("press[%0d].count", i), fifo_count, press_tab[i].count);
            check($sformatf("press[%0d].ovf", i), overflow, press_tab[i].ovf);
            check($sformatf("press[%0d].head", i), key_code, 4'd0);
            check($sformatf("press[%0d].valid", i), key_valid, 1'b1);
        end

        for (int i = 0; i < 4; i++) begin
            check($sformatf("pop[%0d].code", i), key_code, pop_exp[i]);
            key_ready = 1'b1;
            tick(1);
            key_ready = 1'b0;
        end
        check("drained_valid", key_valid, 1'b0);
        check("drained_count", fifo_count, 3'd0);
        check("ovf_sticky", overflow, 1'b1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_ovf", overflow, 1'b0);
        tick(11);

        press(16'h0002, 2, 16'h0000, 0, 2);
        press(16'h0004, 2, 16'h0000, 0, 2);
        press(16'h0010, 2, 16'h0000, 0, 2);
        press(16'h0080, 2, 16'h0000, 0, 2);
        check("fill_count", fifo_count, 3'd4);
        check("fill_head", key_code, 4'd1);
        pat = 16'h0200;
        tick(31);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("pushpop_full_count", fifo_count, 3'd4);
        check("pushpop_full_ovf", overflow, 1'b0);
        check("pushpop_full_head", key_code, 4'd2);
        tick(16);
        pat = '0;
        tick(32);

        en = 1'b0;
        tick(1);
        check("en0_col_out", col_out, 4'hf);
        check("en0_count", fifo_count, 3'd4);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("en0_pop1_count", fifo_count, 3'd3);
        check("en0_pop1_head", key_code, 4'd4);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("en0_pop2_count", fifo_count, 3'd2);
        check("en0_pop2_head", key_code, 4'd7);

        en = 1'b1;
        pat = 16'h0001;
        tick(16);
        check("cand_no_push", fifo_count, 3'd2);
        tick(5);
        nrst = 1'b0;
        tick(1);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_col_out", col_out, 4'hf);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_code", key_code, 4'd0);
        nrst = 1'b1;
        tick(16);
        check("after_rst_frame1", fifo_count, 3'd0);
        tick(16);
        check("after_rst_frame2", fifo_count, 3'd1);
        check("after_rst_code", key_code, 4'd0);
        pat = '0;
        tick(32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_fifo.md
# keypad_scan_fifo

- Parametrised matrix-keypad scanner for the team project, between the GPIO keypad pins and the application logic.
- Drives one-cold column strobes and samples synchronised row inputs.
- Debounces single-key presses over whole scan frames, rejecting multi-key frames.
- Queues debounced key codes in a small FIFO with a valid/ready pop interface and sticky overflow flag.

## Interface
- ROWS, 4, number of row inputs (≥2)
- COLS, 4, number of column strobes (≥2)
- SCAN_DIV, 4, clock cycles each column is driven (≥3)
- DEBOUNCE, 2, consecutive identical frames required to accept a press or a release (≥1)
- FIFO_DEPTH, 4, key-code entries, power of two (≥2)
- CW, derived, key-code width = $clog2(ROWS*COLS)

- clk  in  1  single clock
- nrst  in  1  reset, synchronous, active-low
- en  in  1  scan enable
- clr  in  1  synchronous flush of FIFO and overflow flag
- row_in  in  ROWS  raw row lines, active-high, asynchronous to clk
- col_out  out  COLS  column strobes, active-low one-cold
- key_valid  out  1  FIFO non-empty
- key_code  out  CW  FIFO head, col_idx*ROWS + row_idx
- key_ready  in  1  consumer accepts head
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

## Operation
- row_in passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- Scan counters:
  - col_idx runs 0..COLS-1 and wraps.
  - dwell runs 0..SCAN_DIV-1 per column.
  - col_out = ~(1<<col_idx), registered.
  - For COLS=4: column 0 → 4'he, column 2 → 4'hb.
- Row sample at dwell==SCAN_DIV-1 of each column, classified as:
  - none (all zero)
  - single (exactly one bit set)
  - multi (two or more bits set)
- Frame accumulator across one full column sweep. Frame result:
  - NONE: no column hit.
  - KEY(code): exactly one column returned single and none returned multi.
  - MULTI: otherwise.
  - Evaluated at the last sample of column COLS-1.
- Debounce FSM, advanced once per frame result:
  - IDLE:
    - KEY(c) → CAND, cand=c, cnt=1.
    - If DEBOUNCE==1, push c and go to HELD instead.
  - CAND:
    - KEY(cand): cnt+1; when cnt reaches DEBOUNCE, push cand and go to HELD.
    - KEY(other) → restart CAND with the new code, cnt=1.
    - NONE or MULTI → IDLE.
  - HELD:
    - NONE: rel+1; when rel reaches DEBOUNCE → IDLE.
    - KEY or MULTI: rel=0.
    - No rollover: a second key pressed while one is held is never queued.
- FIFO:
  - push = FSM accept event; pop = key_valid & key_ready.
  - Push when full with no pop: entry dropped, overflow←1.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: pop ignored (key_valid=0); push lands.
  - No bypass: a pushed code appears on key_code the next cycle.
- en=0:
  - col_out all ones.
  - Scan counters, accumulator and FSM cleared to col 0 / IDLE.
  - FIFO contents and popping are retained.
- clr: empties the FIFO and clears overflow. A push in the same cycle is discarded.

## Timing
- Reset values (nrst=0 on a rising clk edge):
  - col_out all ones; key_valid 0; key_code 0; overflow 0; fifo_count 0.
  - FSM IDLE; counters 0; synchroniser 0.
- First cycle after reset release with en=1: col_out = column 0 pattern.
- Row settle: SCAN_DIV-1 cycles between column change and sample. Synchroniser adds 2 cycles; the sample therefore reflects row_in from 2 cycles earlier.
- Frame length F = COLS*SCAN_DIV cycles.
- Press latency:
  - Stable press starting before a frame: key_valid rises 1 cycle after the last sample of the DEBOUNCE-th full frame.
  - Worst case from press: ≤ (DEBOUNCE+1)*F + 3 cycles.
- Release: DEBOUNCE consecutive NONE frames before a new press can be accepted.
- Reset asserted mid-frame or mid-debounce: everything returns to reset values on that edge; the FIFO is emptied.

## Test plan
Defaults: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4, F=16.

- **Column scan:** after reset with en=1, col_out sequence is e,d,b,7 with 4 cycles each. With en=0, col_out = f.
- **Single press:** drive row_in=4'h1 whenever col_out==4'he, held 3 frames → exactly one entry, key_code=0, key_valid within 2F+3 cycles of a frame-aligned press. Release → no further push.
- **Second key:** drive row_in=4'h8 whenever col_out==4'hb, held → code 11. A bounce (1 frame pressed, 1 frame released, repeated) → no push.
- **Multi-key:** rows 4'h3 on column 0, or row 1 on columns 0 and 1 → no push, FSM stays in or returns to IDLE.
- **FIFO:**
  - 5 separate presses with key_ready=0 → fifo_count=4, overflow=1, head=first code.
  - Pop all four → codes in press order, then key_valid=0.
  - clr → overflow=0.
- **Full FIFO, simultaneous push/pop:** with the FIFO full, a push coinciding with key_ready=1 → count stays 4, overflow stays 0.
- **Reset mid-operation:** nrst=0 mid-CAND with 2 queued entries → fifo_count=0, col_out=f. After release, a held key needs the full 2 frames again.
